// File: rtl/enc_dec_pkg.sv
// -----------------------------------------------------------------------------
// enc_dec_pkg
// Shared definitions for the one-hot encoder and the 3-to-8 decoder:
//   DEFAULT_WIDTH - default one-hot vector width
//   clog2_w()     - ceiling log2, usable in parameter expressions
//   code_t        - 3-bit code type shared by encoder output and decoder input
// -----------------------------------------------------------------------------
package enc_dec_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [2:0] code_t;

    // Smallest r with 2**r >= n; returns 1 for n <= 2 so a code is never 0 bits.
    function automatic int clog2_w(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << r) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_index.sv
// -----------------------------------------------------------------------------
// prio_index
// Purely combinational priority index of a bit vector; reusable by arbiters.
// Ports:
//   vec    in   WIDTH   request vector
//   index  out  CODE_W  index of the winning set bit (0 when vec is zero)
//   zero   out  1       vec has no bit set
//   multi  out  1       vec has more than one bit set
// PRIO_HIGH = 1 picks the highest set bit, 0 picks the lowest.
// -----------------------------------------------------------------------------
module prio_index
    import enc_dec_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CODE_W    = clog2_w(WIDTH),
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [WIDTH-1:0]  vec,
    output logic [CODE_W-1:0] index,
    output logic              zero,
    output logic              multi
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        index = '0;
        // The scan order makes the preferred bit the last one written.
        if (PRIO_HIGH) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) index = CODE_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) index = CODE_W'(i);
            end
        end
    end

    assign zero  = ~|vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/encoder8_hs.sv
// -----------------------------------------------------------------------------
// encoder8_hs
// Registered one-hot-to-binary encoder with valid/ready handshake and a
// saturating count of malformed (zero or multi-hot) words.
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   enable     in   1       when low, no new word is accepted
//   in         in   WIDTH   one-hot request word
//   in_valid   in   1       `in` is valid this cycle
//   in_ready   out  1       a word can be accepted this cycle
//   out        out  CODE_W  encoded index
//   out_zero   out  1       accepted word was all zeros
//   out_multi  out  1       accepted word had more than one bit set
//   out_valid  out  1       out / out_zero / out_multi are valid
//   out_ready  in   1       downstream takes the output this cycle
//   err_cnt    out  ERR_W   saturating count of accepted malformed words
//   err_clr    in   1       synchronous clear of err_cnt
// -----------------------------------------------------------------------------
module encoder8_hs
    import enc_dec_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CODE_W    = clog2_w(WIDTH),
    parameter bit PRIO_HIGH = 1'b1,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [WIDTH-1:0]  in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out,
    output logic              out_zero,
    output logic              out_multi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ERR_W-1:0]  err_cnt,
    input  logic              err_clr
);

    logic [CODE_W-1:0] enc_index;
    logic              enc_zero;
    logic              enc_multi;
    logic              accept;
    logic              malformed;

    prio_index #(
        .WIDTH     (WIDTH),
        .CODE_W    (CODE_W),
        .PRIO_HIGH (PRIO_HIGH)
    ) u_prio_index (
        .vec   (in),
        .index (enc_index),
        .zero  (enc_zero),
        .multi (enc_multi)
    );

    // A free slot or a slot being emptied this cycle lets a new word in,
    // giving full throughput with no bubble on a simultaneous take/accept.
    assign in_ready  = enable && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign malformed = accept && (enc_zero || enc_multi);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order; the reset is
    // asynchronous, so it sits in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out       <= enc_index;
            out_zero  <= enc_zero;
            out_multi <= enc_multi;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            // Taken with nothing behind it: drop valid, keep the data fields.
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            // A malformed word arriving with the clear still gets counted.
            err_cnt <= ERR_W'(malformed);
        end else if (malformed && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_encoder8_hs.sv
// -----------------------------------------------------------------------------
// tb_encoder8_hs
// Three encoder8_hs instances share one stimulus stream:
//   dut_hi  - PRIO_HIGH = 1, ERR_W = 8
//   dut_lo  - PRIO_HIGH = 0, ERR_W = 8
//   dut_sat - PRIO_HIGH = 1, ERR_W = 2
// Expected words are queued on accept and compared while held at the output.
// -----------------------------------------------------------------------------
module tb_encoder8_hs;
    import enc_dec_pkg::*;

    typedef struct packed {
        code_t idx_hi;
        code_t idx_lo;
        logic  zero;
        logic  multi;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] din;
    logic       in_valid;
    logic       out_ready;
    logic       err_clr;

    logic       in_ready_hi, in_ready_lo, in_ready_sat;
    logic [2:0] out_hi, out_lo, out_sat;
    logic       zero_hi, zero_lo, zero_sat;
    logic       multi_hi, multi_lo, multi_sat;
    logic       valid_hi, valid_lo, valid_sat;
    logic [7:0] err_hi, err_lo;
    logic [1:0] err_sat;

    int         n_checks;
    int         n_errors;
    exp_t       sb[$];
    int         m_err8;
    int         m_err2;

    encoder8_hs #(.PRIO_HIGH(1'b1), .ERR_W(8)) dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in(din), .in_valid(in_valid),
        .in_ready(in_ready_hi), .out(out_hi), .out_zero(zero_hi), .out_multi(multi_hi),
        .out_valid(valid_hi), .out_ready(out_ready), .err_cnt(err_hi), .err_clr(err_clr)
    );

    encoder8_hs #(.PRIO_HIGH(1'b0), .ERR_W(8)) dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in(din), .in_valid(in_valid),
        .in_ready(in_ready_lo), .out(out_lo), .out_zero(zero_lo), .out_multi(multi_lo),
        .out_valid(valid_lo), .out_ready(out_ready), .err_cnt(err_lo), .err_clr(err_clr)
    );

    encoder8_hs #(.PRIO_HIGH(1'b1), .ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in(din), .in_valid(in_valid),
        .in_ready(in_ready_sat), .out(out_sat), .out_zero(zero_sat), .out_multi(multi_sat),
        .out_valid(valid_sat), .out_ready(out_ready), .err_cnt(err_sat), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding: scan for the first set bit from each end.
    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        bit   found_hi;
        bit   found_lo;
        e        = '0;
        found_hi = 0;
        found_lo = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i] && !found_hi) begin
                e.idx_hi = code_t'(i);
                found_hi = 1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (v[i] && !found_lo) begin
                e.idx_lo = code_t'(i);
                found_lo = 1;
            end
        end
        e.zero  = (v == 8'h00);
        e.multi = ($countones(v) > 1);
        return e;
    endfunction

    // One clock: check outputs at the falling edge, then advance the model
    // across the rising edge. Inputs are driven by the caller beforehand.
    task automatic cycle();
        bit   exp_ready;
        bit   acc;
        bit   take;
        bit   bad;
        exp_t e;
        @(negedge clk);
        check("out_valid", valid_hi, (sb.size() != 0));
        check("out_valid_lo", valid_lo, (sb.size() != 0));
        check("out_valid_sat", valid_sat, (sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_hi", out_hi, sb[0].idx_hi);
            check("out_lo", out_lo, sb[0].idx_lo);
            check("out_sat", out_sat, sb[0].idx_hi);
            check("out_zero", zero_hi, sb[0].zero);
            check("out_multi", multi_hi, sb[0].multi);
        end
        check("err_cnt", err_hi, m_err8);
        check("err_cnt_lo", err_lo, m_err8);
        check("err_cnt_sat", err_sat, m_err2);
        exp_ready = enable && ((sb.size() == 0) || out_ready);
        check("in_ready", in_ready_hi, exp_ready);
        check("in_ready_sat", in_ready_sat, exp_ready);
        acc  = in_valid && exp_ready;
        take = (sb.size() != 0) && out_ready;
        e    = model(din);
        bad  = acc && (e.zero || e.multi);
        @(posedge clk);
        if (take) void'(sb.pop_front());
        if (acc) sb.push_back(e);
        if (err_clr) begin
            m_err8 = bad ? 1 : 0;
            m_err2 = bad ? 1 : 0;
        end else if (bad) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
        in_valid  = v;
        din       = d;
        out_ready = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] bad_words [5];
        n_checks  = 0;
        n_errors  = 0;
        m_err8    = 0;
        m_err2    = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        err_clr   = 1'b0;
        drive(1'b0, 8'h00, 1'b1);

        // Outputs are quiet while reset is held.
        #2;
        check("rst_out_valid", valid_hi, 1'b0);
        check("rst_err_cnt", err_hi, 0);
        check("rst_out", out_hi, 0);
        check("rst_in_ready", in_ready_hi, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Back-to-back one-hot sweep, then drain.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'h01 << i, 1'b1);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b1);
        cycle();

        // Zero word and multi-hot 8'h24 (high -> 5, low -> 2).
        drive(1'b1, 8'h00, 1'b1);
        cycle();
        drive(1'b1, 8'h24, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1);
        cycle();
        check("err_after_malformed", err_hi, 2);

        // Backpressure: 8'h10 held three cycles, then handoff to 8'h40.
        drive(1'b1, 8'h10, 1'b1);
        cycle();
        drive(1'b1, 8'h20, 1'b0);
        repeat (3) cycle();
        drive(1'b1, 8'h40, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1);
        cycle();
        cycle();

        // Enable gating: a held word drains while nothing new is taken.
        drive(1'b1, 8'h02, 1'b0);
        cycle();
        enable = 1'b0;
        drive(1'b1, 8'h08, 1'b0);
        cycle();
        drive(1'b1, 8'h08, 1'b1);
        cycle();
        cycle();
        enable = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        cycle();

        // Five malformed words saturate the 2-bit counter at 3.
        bad_words[0] = 8'h00;
        bad_words[1] = 8'hff;
        bad_words[2] = 8'h03;
        bad_words[3] = 8'h00;
        bad_words[4] = 8'h81;
        foreach (bad_words[i]) begin
            drive(1'b1, bad_words[i], 1'b1);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b1);
        cycle();
        check("err_sat_at_max", err_sat, 3);

        // Clear together with a malformed accept leaves 1; clear alone leaves 0.
        err_clr = 1'b1;
        drive(1'b1, 8'h00, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1);
        cycle();
        err_clr = 1'b0;
        cycle();

        // Randomised traffic, mostly one-hot.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] w;
            w = 8'h01 << $urandom_range(7);
            if ($urandom_range(4) == 0) w = 8'($urandom);
            enable  = ($urandom_range(5) != 0);
            err_clr = ($urandom_range(15) == 0);
            drive(1'($urandom_range(1)), w, 1'($urandom_range(2) != 0));
            cycle();
        end
        enable  = 1'b1;
        err_clr = 1'b0;

        // Reset in the middle of a transfer drops the held word.
        drive(1'b1, 8'h11, 1'b0);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", valid_hi, 1'b0);
        check("async_rst_err_cnt", err_hi, 0);
        check("async_rst_out_zero", zero_hi, 1'b0);
        check("async_rst_out_multi", multi_hi, 1'b0);
        check("async_rst_in_ready", in_ready_hi, 1'b1);
        sb.delete();
        m_err8 = 0;
        m_err2 = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
